alu_share_arbiter: RTL and testbench

//  Shares one combinational 32-bit ALU (ops: add=3'b001, sub=3'b010, or=3'b011) between NREQ requesters.

---
 rtl/alu_share_arbiter_pkg.sv | 22 ++
 rtl/alu_share_arbiter_rr_arbiter.sv | 38 +++
 rtl/alu_share_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - shared opcodes, FSM encodings and helpers for alu_share_arbiter
package alu_share_arbiter_pkg;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } alu_cmd_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// rtl/alu_share_arbiter_rr_arbiter.sv - combinational round-robin one-hot grant
module rr_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [IDW-1:0]  rr_ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_idx_o,
  output logic            grant_any_o
);

  int best_dist;

  // The winner is the valid requester at the smallest circular distance from rr_ptr.
  always_comb begin
    best_dist   = NREQ;
    grant_idx_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid_i[i] && (((i + NREQ - int'(rr_ptr_i)) % NREQ) < best_dist)) begin
        best_dist   = (i + NREQ - int'(rr_ptr_i)) % NREQ;
        grant_idx_o = IDW'(i);
      end
    end
  end

  assign grant_any_o = |req_valid_i;

  always_comb begin
    grant_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_o[i] = grant_any_o && (grant_idx_o == IDW'(i));
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one external 32-bit ALU between NREQ requesters
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*3-1:0] req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_result,
  output logic              rsp_err,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [2:0]        alu_op,
  input  logic [31:0]       alu_y
);

  logic [1:0]      state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  alu_cmd_t        cmd_q, cmd_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_result_q, rsp_result_d;
  logic            rsp_err_q, rsp_err_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  alu_cmd_t        sel_cmd;
  logic            in_idle;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  always_comb begin
    sel_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_cmd.a  = req_a[32*i +: 32];
        sel_cmd.b  = req_b[32*i +: 32];
        sel_cmd.op = req_op[3*i +: 3];
      end
    end
  end

  // The unused encoding 2'd3 behaves as IDLE; reset also masks the grant combinationally.
  assign in_idle   = (state_q != S_EXEC) && (state_q != S_RESP);
  assign req_ready = (in_idle && !reset) ? grant : '0;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cmd_d        = cmd_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      S_EXEC: begin
        rsp_valid_d  = 1'b1;
        rsp_id_d     = id_q;
        rsp_err_d    = !op_is_legal(cmd_q.op);
        rsp_result_d = op_is_legal(cmd_q.op) ? alu_y : 32'h0;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        if (grant_any) begin
          cmd_d    = sel_cmd;
          id_d     = grant_idx;
          rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
          state_d  = S_EXEC;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      cmd_q        <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= 32'h0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cmd_q        <= cmd_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // ALU inputs come straight from the operand registers, so they hold after EXEC.
  assign alu_a      = cmd_q.a;
  assign alu_b      = cmd_q.b;
  assign alu_op     = cmd_q.op;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter with a behavioural model
module tb_alu_share_arbiter;

  localparam int NREQ = 2;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_a = '0;
  logic [NREQ*32-1:0]  req_b = '0;
  logic [NREQ*3-1:0]   req_op = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_result;
  logic                rsp_err;
  logic [31:0]         alu_a, alu_b, alu_y;
  logic [2:0]          alu_op;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  int          m_phase = 0;
  int          m_ptr   = 0;
  int          m_id    = 0;
  int          m_g     = 0;
  int          c_g     = 0;
  logic [31:0] m_la  = '0;
  logic [31:0] m_lb  = '0;
  logic [2:0]  m_lop = '0;
  logic [31:0] m_res = '0;
  logic        m_err = 1'b0;
  logic [NREQ-1:0] c_ready;

  alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_y      (alu_y)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'b001:  return a + b;
      3'b010:  return a - b;
      3'b011:  return a | b;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [2:0] op);
    return op inside {3'b001, 3'b010, 3'b011};
  endfunction

  function automatic int ref_grant(input logic [NREQ-1:0] v, input int ptr);
    logic [NREQ-1:0] t;
    for (int k = 0; k < NREQ; k++) begin
      t = v >> ((ptr + k) % NREQ);
      if (t[0]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // The bench plays the external ALU; unknown opcodes return garbage the DUT must discard.
  always_comb alu_y = ref_alu(alu_a, alu_b, alu_op);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0;
      m_ptr   = 0;
      m_la    = '0;
      m_lb    = '0;
      m_lop   = '0;
    end else if (m_phase == 0) begin
      m_g = ref_grant(req_valid, m_ptr);
      if (m_g >= 0) begin
        m_la    = 32'(req_a >> (32 * m_g));
        m_lb    = 32'(req_b >> (32 * m_g));
        m_lop   = 3'(req_op >> (3 * m_g));
        m_id    = m_g;
        m_ptr   = (m_g + 1) % NREQ;
        m_res   = ref_legal(m_lop) ? ref_alu(m_la, m_lb, m_lop) : 32'h0;
        m_err   = !ref_legal(m_lop);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (rsp_ready) begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      c_g     = ref_grant(req_valid, m_ptr);
      c_ready = (reset || m_phase != 0 || c_g < 0) ? '0 : (NREQ'(1) << c_g);
      chk("m_req_ready", 32'(req_ready), 32'(c_ready));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
      if (m_phase == 2) begin
        chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
        chk("m_rsp_result", rsp_result, m_res);
        chk("m_rsp_err", 32'(rsp_err), 32'(m_err));
      end
      chk("m_alu_a", alu_a, m_la);
      chk("m_alu_b", alu_b, m_lb);
      chk("m_alu_op", 32'(alu_op), 32'(m_lop));
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [NREQ*32-1:0] m32;
    logic [NREQ*3-1:0]  m3;
    m32       = (NREQ*32)'(32'hFFFF_FFFF) << (32 * i);
    m3        = (NREQ*3)'(3'b111) << (3 * i);
    req_a     = (req_a & ~m32) | ((NREQ*32)'(a) << (32 * i));
    req_b     = (req_b & ~m32) | ((NREQ*32)'(b) << (32 * i));
    req_op    = (req_op & ~m3) | ((NREQ*3)'(op) << (3 * i));
    req_valid = req_valid | (NREQ'(1) << i);
  endtask

  task automatic wait_grant(input int i, input string name);
    logic [NREQ-1:0] t;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      t = req_ready >> i;
      n++;
    end while (!t[0] && n < 30);
    chk(name, 32'(t[0]), 32'd1);
    @(posedge clk);
    #1 req_valid = req_valid & ~(NREQ'(1) << i);
  endtask

  task automatic wait_rsp_valid(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 30);
    chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
  endtask

  task automatic wait_rsp(input int id, input logic [31:0] res, input logic err, input string name);
    wait_rsp_valid(name);
    chk({name, "_id"}, 32'(rsp_id), 32'(id));
    chk({name, "_result"}, rsp_result, res);
    chk({name, "_err"}, 32'(rsp_err), 32'(err));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    chk({tag, "_rsp_result"}, rsp_result, 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
    chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    @(posedge clk);
    #1 check_reset_outputs("reset");
    reset  = 1'b0;
    chk_en = 1'b1;

    // Single op: grant is visible in the same cycle, response after two edges.
    set_req(0, 32'd5, 32'd3, 3'b001);
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("t1_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t1_exec_alu_a", alu_a, 32'd5);
    chk("t1_exec_alu_op", 32'(alu_op), 32'd1);
    wait_rsp(0, 32'd8, 1'b0, "t1");

    // Round-robin with both requesters held valid.
    do_reset();
    set_req(0, 32'd10, 32'd20, 3'b001);
    set_req(1, 32'd1, 32'd2, 3'b010);
    for (int k = 0; k < 4; k++) begin
      wait_rsp(k % 2, (k % 2 == 1) ? 32'hFFFF_FFFF : 32'd30, 1'b0, "t2");
    end
    req_valid = '0;

    // Backpressure: response held, no grant to a waiting req1 until acceptance.
    set_req(0, 32'd100, 32'd1, 3'b010);
    set_req(1, 32'd3, 32'd4, 3'b001);
    wait_grant(0, "t3_grant0");
    wait_rsp_valid("t3_first");
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t3_hold_result", rsp_result, 32'd99);
      chk("t3_hold_id", 32'(rsp_id), 32'd0);
      chk("t3_hold_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    wait_rsp(0, 32'd99, 1'b0, "t3_acc");
    @(negedge clk);
    chk("t3_req1_ready", 32'(req_ready), 32'd2);
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp(1, 32'd7, 1'b0, "t3_req1");

    // Wrap-around add and OR.
    set_req(0, 32'hFFFF_FFFF, 32'd1, 3'b001);
    wait_grant(0, "t4_grant0");
    wait_rsp(0, 32'd0, 1'b0, "t4_wrap");
    set_req(1, 32'hF0F0_0000, 32'h0000_0F0F, 3'b011);
    wait_grant(1, "t4_grant1");
    wait_rsp(1, 32'hF0F0_0F0F, 1'b0, "t4_or");

    // Illegal opcode is forwarded but its result is squashed.
    set_req(0, 32'd7, 32'd7, 3'b111);
    wait_grant(0, "t5_grant");
    wait_rsp(0, 32'd0, 1'b1, "t5_illegal");
    chk("t5_alu_op_fwd", 32'(alu_op), 32'd7);
    set_req(0, 32'd2, 32'd3, 3'b001);
    wait_grant(0, "t5_grant_legal");
    wait_rsp(0, 32'd5, 1'b0, "t5_legal");

    // Async reset mid-EXEC, then mid-RESP.
    set_req(0, 32'd9, 32'd9, 3'b001);
    wait_grant(0, "t6_grant_exec");
    #2 reset = 1'b1;
    #1 check_reset_outputs("t6_exec");
    @(posedge clk);
    #1 reset = 1'b0;
    set_req(0, 32'd11, 32'd11, 3'b001);
    wait_grant(0, "t6_grant_resp");
    wait_rsp_valid("t6_resp");
    #2 reset = 1'b1;
    #1 check_reset_outputs("t6_resp");
    @(posedge clk);
    #1 reset = 1'b0;
    set_req(1, 32'd40, 32'd2, 3'b001);
    wait_grant(1, "t6_grant_req1");
    wait_rsp(1, 32'd42, 1'b0, "t6_req1");

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
